// File: rtl/logic_acc_unit.sv
// logic_acc_unit: registered WIDTH-bit bitwise logic unit with eight operations,
// a single-beat mode and a frame-accumulate mode that folds a stream of beats
// into one result. Ready/valid on input and output, one registered result slot.
module logic_acc_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic             q_zero,
   output logic             q_ones,
   output logic [CNT_W-1:0] beats
);

   typedef enum logic {S_IDLE, S_ACCUM} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [2:0]         lop_q, lop_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic               ones_q, ones_d;
   logic [CNT_W-1:0]   beats_q, beats_d;
   logic               valid_q, valid_d;

   logic               accept;
   logic [WIDTH-1:0]   single_val;
   logic [WIDTH-1:0]   fold_val;
   logic [CNT_W-1:0]   cnt_inc;

   // Pure bitwise operation; codes 6 and 7 look only at x.
   function automatic logic [WIDTH-1:0] bit_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [2:0]       o);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x & y);
         3'd4:    return ~(x | y);
         3'd5:    return ~(x ^ y);
         3'd6:    return x;
         default: return ~x;
      endcase
   endfunction

   // The slot can take a beat when it is empty or its result leaves this cycle.
   assign in_ready   = !valid_q || out_ready;
   assign accept     = in_valid && in_ready;
   assign single_val = bit_op(a, b, op);
   assign fold_val   = bit_op(acc_q, a, lop_q);
   assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   assign out_valid  = valid_q;
   assign q          = res_q;
   assign q_zero     = zero_q;
   assign q_ones     = ones_q;
   assign beats      = beats_q;

   // State register plus datapath registers; reset discards any partial frame or pending result.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         lop_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ones_q  <= 1'b0;
         beats_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         lop_q   <= lop_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ones_q  <= ones_d;
         beats_q <= beats_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic: a multi-beat frame opens in IDLE and closes on its last beat.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && acc_en && !last) state_d = S_ACCUM;
         S_ACCUM: if (accept && last)            state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath logic: fold beats into acc, load the result slot, release it on handshake.
   always_comb begin
      acc_d   = acc_q;
      lop_d   = lop_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ones_d  = ones_q;
      beats_d = beats_q;
      valid_d = valid_q;

      // A consumed result frees the slot; a load below in the same cycle overrides this.
      if (valid_q && out_ready) valid_d = 1'b0;

      if (accept) begin
         case (state_q)
            S_IDLE: begin
               if (!acc_en || last) begin
                  res_d   = single_val;
                  zero_d  = (single_val == '0);
                  ones_d  = &single_val;
                  beats_d = CNT_W'(1);
                  valid_d = 1'b1;
               end else begin
                  acc_d = single_val;
                  lop_d = op;
                  cnt_d = CNT_W'(1);
               end
            end
            S_ACCUM: begin
               if (last) begin
                  res_d   = fold_val;
                  zero_d  = (fold_val == '0);
                  ones_d  = &fold_val;
                  beats_d = cnt_inc;
                  valid_d = 1'b1;
               end else begin
                  acc_d = fold_val;
                  cnt_d = cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_acc_unit.sv
// tb_logic_acc_unit: directed and randomized stimulus for logic_acc_unit,
// checked against a frame-level reference model. Two instances share the
// inputs: the default CNT_W=4 and a CNT_W=2 copy for counter saturation.
module tb_logic_acc_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;
   logic         acc_en = 1'b0;
   logic         last = 1'b0;
   logic         out_ready = 1'b1;

   logic         in_ready, out_valid, q_zero, q_ones;
   logic [W-1:0] q;
   logic [3:0]   beats;
   logic         in_ready_s, out_valid_s, q_zero_s, q_ones_s;
   logic [W-1:0] q_s;
   logic [1:0]   beats_s;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: pending result and the beats of the open frame.
   bit           m_valid = 1'b0;
   logic [W-1:0] m_q;
   int           m_beats;
   logic [W-1:0] fr_a[$];
   logic [W-1:0] fr_b;
   logic [2:0]   fr_op;

   logic [W-1:0] sweep_exp[8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};

   always #5 clk = ~clk;

   logic_acc_unit #(.WIDTH(W), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_en(acc_en), .last(last),
      .out_valid(out_valid), .out_ready(out_ready),
      .q(q), .q_zero(q_zero), .q_ones(q_ones), .beats(beats)
   );

   logic_acc_unit #(.WIDTH(W), .CNT_W(2)) u_dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .op(op), .acc_en(acc_en), .last(last),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .q(q_s), .q_zero(q_zero_s), .q_ones(q_ones_s), .beats(beats_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] o);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x & y);
         3'd4:    return ~(x | y);
         3'd5:    return ~(x ^ y);
         3'd6:    return x;
         default: return ~x;
      endcase
   endfunction

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic check_outputs();
      check("out_valid", out_valid, m_valid);
      check("out_valid_sat", out_valid_s, m_valid);
      if (m_valid) begin
         check("q", q, m_q);
         check("q_zero", q_zero, m_q == '0);
         check("q_ones", q_ones, &m_q);
         check("beats", beats, sat(m_beats, 4));
         check("q_sat", q_s, m_q);
         check("beats_sat", beats_s, sat(m_beats, 2));
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
   task automatic step(input bit vld, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [2:0] opi, input bit acc, input bit lst, input bit ordy);
      bit           taken;
      logic [W-1:0] r;
      @(negedge clk);
      in_valid  = vld;
      a         = ai;
      b         = bi;
      op        = opi;
      acc_en    = acc;
      last      = lst;
      out_ready = ordy;
      #1;
      check("in_ready", in_ready, !m_valid || ordy);
      check("in_ready_sat", in_ready_s, !m_valid || ordy);
      taken = vld && (!m_valid || ordy);
      @(posedge clk);
      if (m_valid && ordy) m_valid = 1'b0;
      if (taken) begin
         if (fr_a.size() == 0) begin
            if (!acc || lst) begin
               m_valid = 1'b1;
               m_q     = ref_op(ai, bi, opi);
               m_beats = 1;
            end else begin
               fr_a.push_back(ai);
               fr_b  = bi;
               fr_op = opi;
            end
         end else begin
            fr_a.push_back(ai);
            if (lst) begin
               r = ref_op(fr_a[0], fr_b, fr_op);
               for (int i = 1; i < fr_a.size(); i++) r = ref_op(r, fr_a[i], fr_op);
               m_valid = 1'b1;
               m_q     = r;
               m_beats = fr_a.size();
               fr_a.delete();
            end
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_valid = 1'b0;
      fr_a.delete();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_q", q, 8'h00);
      check("rst_q_zero", q_zero, 1'b1);
      check("rst_q_ones", q_ones, 1'b0);
      check("rst_beats", beats, 4'd0);
      check("rst_out_valid_sat", out_valid_s, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // Single-mode sweep over all eight operations.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0, 1'b1);
         check("sweep_q", q, sweep_exp[i]);
         check("sweep_beats", beats, 4'd1);
      end
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

      // Accumulate AND frame; op/acc_en on later beats must be ignored.
      step(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0, 1'b1);
      check("acc_no_out1", out_valid, 1'b0);
      step(1'b1, 8'h3C, 8'h00, 3'd5, 1'b0, 1'b0, 1'b1);
      check("acc_no_out2", out_valid, 1'b0);
      step(1'b1, 8'h36, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1);
      check("acc_q", q, 8'h04);
      check("acc_beats", beats, 4'd3);
      check("acc_q_zero", q_zero, 1'b0);

      // Backpressure: result held, then swapped without a bubble.
      step(1'b1, 8'hAA, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h11, 8'h22, 3'd1, 1'b0, 1'b0, 1'b0);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_q_held", q, 8'h0A);
      end
      step(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b1);
      check("bp_new_valid", out_valid, 1'b1);
      check("bp_new_q", q, 8'hFF);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

      // Saturation: six-beat XOR frame.
      step(1'b1, 8'h01, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h01, 8'hFF, 3'd0, 1'b1, 1'b1, 1'b1);
      check("sat_q", q_s, 8'h00);
      check("sat_q_zero", q_zero_s, 1'b1);
      check("sat_beats2", beats_s, 2'd3);
      check("sat_beats4", beats, 4'd6);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a frame, then a single beat.
      step(1'b1, 8'h0F, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h0F, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
      do_reset();
      step(1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, 1'b0, 1'b1);
      check("mid_rst_q", q, 8'hFF);
      check("mid_rst_q_ones", q_ones, 1'b1);
      check("mid_rst_beats", beats, 4'd1);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      check("mid_rst_no_stale", out_valid, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(3, 0) != 0,
              W'($urandom), W'($urandom), 3'($urandom_range(7, 0)),
              $urandom_range(1, 0) == 1, $urandom_range(9, 0) < 2,
              $urandom_range(9, 0) < 7);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
